// File: rtl/io_output_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_output_ctrl_if : CPU store port and LED / 7-segment drive of io_output_ctrl
// Revision 1.0
// ----------------------------------------------------------------------------
interface io_output_ctrl_if;
  logic        mem_write;
  logic        LedCtrl;
  logic        SegCtrl;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [15:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  modport master (
    output mem_write, LedCtrl, SegCtrl, address, write_data,
    input  led_out, seg_an, seg_out
  );

  modport slave (
    input  mem_write, LedCtrl, SegCtrl, address, write_data,
    output led_out, seg_an, seg_out
  );
endinterface
`default_nettype wire

// File: rtl/io_output_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_output_ctrl : memory-mapped LED register and 8-digit multiplexed 7-seg driver
// Revision 1.0
// ----------------------------------------------------------------------------
module io_output_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  io_output_ctrl_if.slave  bus
);

  localparam int          PW                = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] c_last          = PW'(SCAN_DIV - 1);
  localparam logic [31:0] c_addr_led_full   = 32'hFFFF_FFE1;
  localparam logic [31:0] c_addr_led_low    = 32'hFFFF_FFE3;
  localparam logic [31:0] c_addr_seg_data   = 32'hFFFF_FFE5;
  localparam logic [31:0] c_addr_seg_mask   = 32'hFFFF_FFE7;

  logic [15:0]   r_led;
  logic [31:0]   r_seg_data;
  logic [7:0]    r_seg_mask;
  logic [PW-1:0] r_prescale;
  logic [2:0]    r_idx;
  logic [7:0]    r_seg_an;
  logic [7:0]    r_seg_out;

  logic       w_wr_led_full;
  logic       w_wr_led_low;
  logic       w_wr_seg_data;
  logic       w_wr_seg_mask;
  logic [3:0] w_nibble;
  logic [7:0] w_glyph;
  logic       w_lit;

  always_comb begin
    w_wr_led_full = bus.mem_write && bus.LedCtrl && (bus.address == c_addr_led_full);
    w_wr_led_low  = bus.mem_write && bus.LedCtrl && (bus.address == c_addr_led_low);
    w_wr_seg_data = bus.mem_write && bus.SegCtrl && (bus.address == c_addr_seg_data);
    w_wr_seg_mask = bus.mem_write && bus.SegCtrl && (bus.address == c_addr_seg_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led      <= 16'h0000;
      r_seg_data <= 32'h0000_0000;
      r_seg_mask <= 8'hFF;
    end else begin
      if (w_wr_led_full) r_led      <= bus.write_data[15:0];
      if (w_wr_led_low)  r_led[7:0] <= bus.write_data[7:0];
      if (w_wr_seg_data) r_seg_data <= bus.write_data;
      if (w_wr_seg_mask) r_seg_mask <= bus.write_data[7:0];
    end
  end

  // Digit scan runs free of the store path so stores never shift the timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_idx      <= 3'd0;
    end else if (r_prescale == c_last) begin
      r_prescale <= '0;
      r_idx      <= r_idx + 3'd1;
    end else begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  always_comb begin
    w_nibble = r_seg_data[{r_idx, 2'b00} +: 4];
    w_lit    = r_seg_mask[r_idx];
    w_glyph  = 8'hFF;
    case (w_nibble)
      4'h0: w_glyph = 8'hC0;
      4'h1: w_glyph = 8'hF9;
      4'h2: w_glyph = 8'hA4;
      4'h3: w_glyph = 8'hB0;
      4'h4: w_glyph = 8'h99;
      4'h5: w_glyph = 8'h92;
      4'h6: w_glyph = 8'h82;
      4'h7: w_glyph = 8'hF8;
      4'h8: w_glyph = 8'h80;
      4'h9: w_glyph = 8'h90;
      4'hA: w_glyph = 8'h88;
      4'hB: w_glyph = 8'h83;
      4'hC: w_glyph = 8'hC6;
      4'hD: w_glyph = 8'hA1;
      4'hE: w_glyph = 8'h86;
      4'hF: w_glyph = 8'h8E;
      default: w_glyph = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_an  <= 8'hFF;
      r_seg_out <= 8'hFF;
    end else begin
      r_seg_an  <= w_lit ? ~(8'b1 << r_idx) : 8'hFF;
      r_seg_out <= w_lit ? w_glyph : 8'hFF;
    end
  end

  assign bus.led_out = r_led;
  assign bus.seg_an  = r_seg_an;
  assign bus.seg_out = r_seg_out;

endmodule
`default_nettype wire

// File: tb/tb_io_output_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_output_ctrl : scoreboard bench for io_output_ctrl with an abstract model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_io_output_ctrl;

  localparam int SCAN = 4;

  typedef struct packed {
    logic [15:0] led;
    logic [7:0]  an;
    logic [7:0]  seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  io_output_ctrl_if bus ();

  io_output_ctrl #(.SCAN_DIV(SCAN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: registers as the CPU sees them plus edges elapsed since reset.
  logic [15:0] m_led;
  logic [31:0] m_data;
  logic [7:0]  m_mask;
  int          m_k;

  task automatic step(input logic r, input logic mw, input logic le, input logic se,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   dg;
    @(negedge clk);
    rst            = r;
    bus.mem_write  = mw;
    bus.LedCtrl    = le;
    bus.SegCtrl    = se;
    bus.address    = a;
    bus.write_data = d;
    if (r) begin
      m_led  = 16'h0;
      m_data = 32'h0;
      m_mask = 8'hFF;
      m_k    = 0;
      e      = '{led: 16'h0, an: 8'hFF, seg: 8'hFF};
    end else begin
      dg    = (m_k / SCAN) % 8;
      e.an  = m_mask[dg] ? ~(8'h01 << dg) : 8'hFF;
      e.seg = m_mask[dg] ? hex_tab[(m_data >> (4 * dg)) & 32'hF] : 8'hFF;
      if (mw && le && a == 32'hFFFF_FFE1) m_led = d[15:0];
      if (mw && le && a == 32'hFFFF_FFE3) m_led = {m_led[15:8], d[7:0]};
      if (mw && se && a == 32'hFFFF_FFE5) m_data = d;
      if (mw && se && a == 32'hFFFF_FFE7) m_mask = d[7:0];
      e.led = m_led;
      m_k++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (bus.led_out !== e.led) begin
          n_fail++;
          $display("FAIL led_out @%0t: got %h expected %h", $time, bus.led_out, e.led);
        end
        n_checks++;
        if (bus.seg_an !== e.an) begin
          n_fail++;
          $display("FAIL seg_an @%0t: got %h expected %h", $time, bus.seg_an, e.an);
        end
        n_checks++;
        if (bus.seg_out !== e.seg) begin
          n_fail++;
          $display("FAIL seg_out @%0t: got %h expected %h", $time, bus.seg_out, e.seg);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] addr_pick [6];
    logic [31:0] a;
    rst            = 1'b1;
    bus.mem_write  = 1'b0;
    bus.LedCtrl    = 1'b0;
    bus.SegCtrl    = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(3);

    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFE1, 32'h1234_ABCD);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFE3, 32'h0000_00FF);
    idle(2);

    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFE5, 32'h89AB_CDEF);
    idle(36);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFE7, 32'h0000_000F);
    idle(34);

    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFE1, 32'h0000_5555);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFE1, 32'h0000_6666);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFE9, 32'h0000_7777);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFE1, 32'h0000_8888);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFE1, 32'h0000_9999);
    idle(2);

    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFE5, 32'h7654_3210);
    idle(22);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(10);

    // Random traffic, address mostly drawn from the decoded windows.
    addr_pick = '{32'hFFFF_FFE1, 32'hFFFF_FFE3, 32'hFFFF_FFE5,
                  32'hFFFF_FFE7, 32'hFFFF_FFE9, 32'hFFFF_FFE0};
    for (int i = 0; i < 1500; i++) begin
      a = addr_pick[$urandom_range(0, 5)];
      if ($urandom_range(0, 15) == 0) a = $urandom;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
